// File: rtl/pre_set_tab_sat_if.sv
// Request/response bundle for the saturating-counter pattern table.
// Master drives clr/read/update requests; slave returns ready and the registered read result.
interface pre_set_tab_sat_if #(
  parameter int SET_BITS = 2,
  parameter int IDX_BITS = 10,
  parameter int CNT_W    = 2
) ();
  logic                clr;
  logic                ready;
  logic                rd_en;
  logic [SET_BITS-1:0] rd_set;
  logic [IDX_BITS-1:0] rd_idx;
  logic                rd_vld;
  logic [CNT_W-1:0]    rd_data;
  logic                rd_taken;
  logic                up_en;
  logic [SET_BITS-1:0] up_set;
  logic [IDX_BITS-1:0] up_idx;
  logic                up_taken;

  modport master (
    output clr, rd_en, rd_set, rd_idx, up_en, up_set, up_idx, up_taken,
    input  ready, rd_vld, rd_data, rd_taken
  );

  modport slave (
    input  clr, rd_en, rd_set, rd_idx, up_en, up_set, up_idx, up_taken,
    output ready, rd_vld, rd_data, rd_taken
  );
endinterface

// File: rtl/pre_set_tab_sat.sv
// Set-indexed table of saturating counters with internal read-modify-write; reads return one cycle later.
// No backpressure: requests while ready=0 (init sweep) are dropped, requests in RUN are always taken.
module pre_set_tab_sat #(
  parameter int SET_BITS = 2,
  parameter int IDX_BITS = 10,
  parameter int CNT_W    = 2,
  parameter int INIT_VAL = 1
) (
  input  logic               clk,
  input  logic               reset,
  pre_set_tab_sat_if.slave   bus
);
  localparam int AW = SET_BITS + IDX_BITS;
  localparam int D  = 1 << AW;

  typedef logic [AW-1:0]    addr_t;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef enum logic { S_INIT, S_RUN } state_t;

  cnt_t   mem_q [D];
  state_t state_q, state_d;
  addr_t  ptr_q, ptr_d;
  logic   rd_vld_q, rd_vld_d;
  cnt_t   rd_data_q, rd_data_d;

  logic   ready, rd_acc, up_acc, wr_en;
  addr_t  rd_addr, up_addr, wr_addr;
  cnt_t   up_old, up_new, wr_val;

  always_comb begin
    ready   = (state_q == S_RUN);
    rd_acc  = ready && bus.rd_en;
    up_acc  = ready && bus.up_en;
    rd_addr = {bus.rd_idx, bus.rd_set};
    up_addr = {bus.up_idx, bus.up_set};

    // Saturate at both ends instead of wrapping.
    up_old = mem_q[up_addr];
    if (bus.up_taken) up_new = (up_old == '1) ? up_old : up_old + cnt_t'(1);
    else              up_new = (up_old == '0) ? up_old : up_old - cnt_t'(1);

    state_d   = state_q;
    ptr_d     = ptr_q;
    wr_en     = 1'b0;
    wr_addr   = up_addr;
    wr_val    = up_new;
    rd_vld_d  = rd_acc;
    rd_data_d = rd_data_q;

    case (state_q)
      S_INIT: begin
        wr_en   = 1'b1;
        wr_addr = ptr_q;
        wr_val  = cnt_t'(INIT_VAL);
        ptr_d   = ptr_q + addr_t'(1);
        if (ptr_q == '1) state_d = S_RUN;
      end
      S_RUN: begin
        wr_en = up_acc;
        if (bus.clr) begin
          state_d = S_INIT;
          ptr_d   = '0;
        end
      end
      default: state_d = S_INIT;
    endcase

    // Same-address update in the same cycle is forwarded so the read sees the new count.
    if (rd_acc) rd_data_d = (up_acc && (up_addr == rd_addr)) ? up_new : mem_q[rd_addr];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_INIT;
      ptr_q     <= '0;
      rd_vld_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      rd_vld_q  <= rd_vld_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Table storage has no reset; the init sweep establishes its contents.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_val;
  end

  assign bus.ready    = ready;
  assign bus.rd_vld   = rd_vld_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_taken = rd_data_q[CNT_W-1];
endmodule

// File: doc/pre_set_tab_sat.md
Name: pre_set_tab_sat

Overview:
- Parametrised successor to the set-indexed pattern history table.
- Holds 2^(SET_BITS+IDX_BITS) saturating counters of CNT_W bits, addressed by {tab_idx, set}.
- Performs the counter read-modify-write internally from a taken/not-taken outcome, with a registered prediction read port.
- Includes a sequential init sweep, because the table array has no asynchronous clear. Sits between the history register/index hash and the fetch-stage predict logic.

Parameters:
SET_BITS, 2, width of set select; sets = 2^SET_BITS
IDX_BITS, 10, width of table index; entries per set = 2^IDX_BITS
CNT_W, 2, saturating counter width (>=1)
INIT_VAL, 1, value written to every counter by the init sweep (weakly not-taken for CNT_W=2)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
clr  input  1  pulse in RUN: restart init sweep
ready  output  1  1 in RUN state only
rd_en  input  1  prediction read request
rd_set  input  SET_BITS  read set select
rd_idx  input  IDX_BITS  read table index
rd_vld  output  1  rd_data/rd_taken valid (1 cycle after accepted rd_en)
rd_data  output  CNT_W  counter value read
rd_taken  output  1  MSB of rd_data (predict taken)
up_en  input  1  outcome update request
up_set  input  SET_BITS  update set select
up_idx  input  IDX_BITS  update table index
up_taken  input  1  resolved outcome: 1 increments, 0 decrements

Behaviour:
- Entry address A = {idx, set}, SET_BITS+IDX_BITS wide. Depth D = 2^(SET_BITS+IDX_BITS).
- Reset (reset=0, async): state=INIT, init pointer=0, ready=0, rd_vld=0, rd_data=0, rd_taken=0. Array contents are not reset.
- States:
  - INIT: each cycle writes INIT_VAL to array[ptr], then ptr++. Takes exactly D cycles, ptr = 0..D-1. After the write at ptr=D-1, go to RUN, so ready=1 starting the next cycle.
  - RUN: normal operation. clr=1 in RUN -> INIT with ptr=0. ready falls the next cycle. Any rd/up issued in that same cycle is still serviced.
  - clr during INIT: ignored (sweep continues).
- Requests are accepted only when ready=1. rd_en/up_en while ready=0 are dropped: no array write, rd_vld stays 0.
- Read: accepted rd_en in cycle N -> rd_vld=1, rd_data=counter, rd_taken=rd_data[CNT_W-1] in cycle N+1. Without rd_en, rd_vld=0 and rd_data/rd_taken hold their last values.
- Update: accepted up_en in cycle N -> array[A] updates at the end of cycle N.
  - up_taken=1: cnt = (cnt==2^CNT_W-1) ? cnt : cnt+1.
  - up_taken=0: cnt = (cnt==0) ? 0 : cnt-1.
  - No wrap-around in either direction.
- Same-cycle read and update of the same A: the read returns the post-update (saturated) value (write-through bypass).
- Same-cycle read and update of different A: independent; the read returns the pre-existing value.
- Back-to-back updates to the same A: each applies to the result of the previous one. No lost updates.
- Reset asserted mid-INIT or mid-RUN: immediate return to the reset values above and a full sweep restart after release.
- Read/update index inputs are X-tolerant when the corresponding enable is 0.

Test Plan (SET_BITS=1, IDX_BITS=3, CNT_W=2, INIT_VAL=1; D=16):
- Release reset at t0 -> ready=0 for exactly 16 cycles, then 1. Read of every {idx,set} -> rd_vld=1 next cycle, rd_data=01, rd_taken=0.
- Saturate up: 4x up_en, up_taken=1 at set=1, idx=5 -> reads give 10, 11, 11, 11 after each update. rd_taken=1 from the first update onward.
- Saturate down: 3x up_taken=0 at set=0, idx=2 -> 00 after the first, stays 00. Neighbour set=1, idx=2 still reads 01.
- Bypass: same cycle up_en (taken) and rd_en at set=0, idx=7 holding 01 -> rd_data=10 next cycle. A different-address same-cycle read returns the old value.
- Dropped requests: rd_en/up_en during INIT -> rd_vld=0, and the table reads INIT_VAL after the sweep.
- clr in RUN after modifying entries -> ready low 16 cycles, all entries read 01. Reset pulsed at sweep cycle 7 -> ready stays 0 for 16 cycles after release.
